// File: rtl/debounce_edge.sv
// debounce_edge: turns a raw asynchronous button/switch input into a clean,
// clock-synchronous level with one-cycle rise/fall strobes and a wrapping
// press counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOW       | accepted level is 0, synchronised input is 0
// CHK_HIGH  | input went 1, counting stable cycles before accepting a rise
// HIGH      | accepted level is 1, synchronised input is 1
// CHK_LOW   | input went 0, counting stable cycles before accepting a fall
module debounce_edge #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16,
  parameter int PCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_in,
  output logic              btn_level,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              busy,
  output logic [PCNT_W-1:0] press_count
);

  localparam logic [1:0] ST_LOW      = 2'd0;
  localparam logic [1:0] ST_CHK_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;
  localparam logic [1:0] ST_CHK_LOW  = 2'd3;

  // Terminal count: the value cnt holds on the last qualifying cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic              sync0;
  logic              sync1;
  logic              s;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              level_nxt;
  logic              rise_nxt;
  logic              fall_nxt;
  logic              busy_nxt;
  logic [PCNT_W-1:0] pcnt_nxt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn_in;
      sync1 <= sync0;
    end
  end

  assign s = sync1;

  // Next-state and next-output decode for the qualification FSM.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    pcnt_nxt  = press_count;
    case (state)
      ST_LOW: begin
        if (s) begin
          state_nxt = ST_CHK_HIGH;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_HIGH: begin
        if (!s) begin
          // Bounce: drop the candidate without touching the outputs.
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          pcnt_nxt  = press_count + PCNT_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_nxt = ST_CHK_LOW;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_LOW: begin
        if (s) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
    // busy is registered alongside the state so it matches it cycle for cycle.
    busy_nxt = (state_nxt == ST_CHK_HIGH) || (state_nxt == ST_CHK_LOW);
  end

  // State, stability counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOW;
      cnt         <= '0;
      btn_level   <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      busy        <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      rise_pulse  <= rise_nxt;
      fall_pulse  <= fall_nxt;
      busy        <= busy_nxt;
      press_count <= pcnt_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with STABLE_CYCLES=4.
module tb_debounce_edge;

  localparam int STABLE = 4;
  localparam int PCW    = 8;
  localparam int NVEC   = 18;

  logic           clk;
  logic           rst_n;
  logic           btn_in;
  logic           btn_level;
  logic           rise_pulse;
  logic           fall_pulse;
  logic           busy;
  logic [PCW-1:0] press_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           btn;
    logic           lvl;
    logic           rise;
    logic           fall;
    logic           busy;
    logic [PCW-1:0] pcnt;
  } vec_t;

  vec_t vecs[NVEC];

  debounce_edge #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(16),
    .PCNT_W(PCW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy(busy),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    btn_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic b, input logic l, input logic r,
                         input logic f, input logic bz, input int pc);
    vecs[i].btn  = b;
    vecs[i].lvl  = l;
    vecs[i].rise = r;
    vecs[i].fall = f;
    vecs[i].busy = bz;
    vecs[i].pcnt = PCW'(pc);
  endtask

  task automatic press_release();
    btn_in = 1'b1;
    repeat (8) tick();
    btn_in = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    logic           saw_busy_hi;
    logic           saw_busy_lo;
    logic [PCW-1:0] exp_pc;

    // Press then release; entry i is driven before edge i and checked after it.
    //          idx btn lvl rise fall busy pcnt
    set_vec( 0, 1, 0, 0, 0, 0, 0);
    set_vec( 1, 1, 0, 0, 0, 0, 0);
    set_vec( 2, 1, 0, 0, 0, 1, 0);
    set_vec( 3, 1, 0, 0, 0, 1, 0);
    set_vec( 4, 1, 0, 0, 0, 1, 0);
    set_vec( 5, 1, 0, 0, 0, 1, 0);
    set_vec( 6, 1, 1, 1, 0, 0, 1);
    set_vec( 7, 1, 1, 0, 0, 0, 1);
    set_vec( 8, 1, 1, 0, 0, 0, 1);
    set_vec( 9, 0, 1, 0, 0, 0, 1);
    set_vec(10, 0, 1, 0, 0, 0, 1);
    set_vec(11, 0, 1, 0, 0, 1, 1);
    set_vec(12, 0, 1, 0, 0, 1, 1);
    set_vec(13, 0, 1, 0, 0, 1, 1);
    set_vec(14, 0, 1, 0, 0, 1, 1);
    set_vec(15, 0, 0, 0, 1, 0, 1);
    set_vec(16, 0, 0, 0, 0, 0, 1);
    set_vec(17, 0, 0, 0, 0, 0, 1);

    rst_n  = 1'b0;
    btn_in = 1'b0;
    #2;
    chk("reset_level", int'(btn_level), 0);
    chk("reset_rise", int'(rise_pulse), 0);
    chk("reset_fall", int'(fall_pulse), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pcnt", int'(press_count), 0);
    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      btn_in = vecs[i].btn;
      tick();
      chk($sformatf("vec%0d_level", i), int'(btn_level), int'(vecs[i].lvl));
      chk($sformatf("vec%0d_rise", i), int'(rise_pulse), int'(vecs[i].rise));
      chk($sformatf("vec%0d_fall", i), int'(fall_pulse), int'(vecs[i].fall));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_pcnt", i), int'(press_count), int'(vecs[i].pcnt));
    end

    // Bounce: 3 high, 2 low, 2 high, 3 low, five times; nothing is accepted.
    do_reset();
    saw_busy_hi = 1'b0;
    saw_busy_lo = 1'b0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 10; c++) begin
        btn_in = (c < 3) || (c == 5) || (c == 6);
        tick();
        if (busy) saw_busy_hi = 1'b1;
        else      saw_busy_lo = 1'b1;
        chk("bounce_level", int'(btn_level), 0);
        chk("bounce_rise", int'(rise_pulse), 0);
        chk("bounce_pcnt", int'(press_count), 0);
      end
    end
    chk("bounce_busy_hi", int'(saw_busy_hi), 1);
    chk("bounce_busy_lo", int'(saw_busy_lo), 1);

    // Wrap: 256 clean press/release pairs.
    do_reset();
    exp_pc = '0;
    for (int p = 1; p <= 256; p++) begin
      press_release();
      exp_pc = exp_pc + PCW'(1);
      chk($sformatf("wrap_pair%0d", p), int'(press_count), int'(exp_pc));
      if (p == 255) chk("wrap_at_255", int'(press_count), 255);
      if (p == 256) chk("wrap_at_256", int'(press_count), 0);
    end

    // Reset while cnt=2 in CHK_HIGH, after one accepted press.
    do_reset();
    press_release();
    chk("midrst_pre_pcnt", int'(press_count), 1);
    btn_in = 1'b1;
    repeat (5) tick();
    chk("midrst_busy_before", int'(busy), 1);
    rst_n  = 1'b0;
    btn_in = 1'b0;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rise", int'(rise_pulse), 0);
    chk("midrst_fall", int'(fall_pulse), 0);
    chk("midrst_pcnt", int'(press_count), 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("midrst_after_rise", int'(rise_pulse), 0);
      chk("midrst_after_level", int'(btn_level), 0);
    end
    chk("midrst_after_pcnt", int'(press_count), 0);

    // Button held through reset release.
    rst_n  = 1'b0;
    btn_in = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk($sformatf("held_rise_e%0d", e), int'(rise_pulse), (e == 6) ? 1 : 0);
      chk($sformatf("held_level_e%0d", e), int'(btn_level), (e >= 6) ? 1 : 0);
    end
    chk("held_pcnt", int'(press_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Conditions a raw asynchronous pushbutton/switch input into a clean, glitch-free, clock-synchronous level that drives the d input of the downstream d_ff stage.
- Synchronises the input, rejects bounce with a stability counter and state machine, and emits one-cycle rise/fall strobes.
- Keeps a wrapping press counter for the board display logic.

Parameters:
- STABLE_CYCLES, 50000, consecutive synchronised cycles the input must hold a new value before it is accepted; legal range 1 to 2**CNT_W.
- CNT_W, 16, width of the internal stability counter.
- PCNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw asynchronous button or switch input.
- btn_level  output  1  debounced level; feeds the d input of d_ff.
- rise_pulse  output  1  one-cycle strobe when btn_level goes 0->1.
- fall_pulse  output  1  one-cycle strobe when btn_level goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.
- press_count  output  PCNT_W  count of accepted rising edges, wraps.

Behaviour:
- Reset: rst_n low asynchronously clears sync0, sync1, counter and all outputs to 0, and sets the FSM to LOW. Release is sampled on the next posedge.
- Synchroniser: two flops, sync0 <= btn_in and sync1 <= sync0. Only sync1 (called s) feeds the FSM.
- FSM states: LOW, CHK_HIGH, HIGH, CHK_LOW. The state is registered; all outputs are registered.
- LOW: s=1 moves to CHK_HIGH with cnt=0; otherwise stay.
- CHK_HIGH:
  - s=0 returns to LOW and clears cnt (bounce rejected; no output change).
  - s=1 with cnt=STABLE_CYCLES-1 moves to HIGH, sets btn_level=1, rise_pulse=1 and press_count+1.
  - Otherwise cnt+1.
- HIGH and CHK_LOW mirror LOW and CHK_HIGH with the polarity inverted. Acceptance gives btn_level=0 and fall_pulse=1; press_count is unchanged.
- Latency: btn_in set up before edge 0 and held gives btn_level changing at edge STABLE_CYCLES+2.
- Pulses are high for exactly one cycle, in the same cycle btn_level first shows its new value. rise_pulse and fall_pulse are never high together.
- busy is 1 exactly when the state is CHK_HIGH or CHK_LOW.
- press_count wraps from 2**PCNT_W-1 to 0 with no flag.
- cnt never exceeds STABLE_CYCLES-1; no overflow is possible within the legal parameter range.
- STABLE_CYCLES=1: a single stable cycle in CHK_* is accepted, giving a latency of 3 edges.
- Reset mid-qualification: the partial count is discarded and no pulse is emitted.
- If btn_in is already high at reset release, the block passes through CHK_HIGH and emits a normal rise_pulse. Downstream logic must tolerate this.
- Input changes shorter than STABLE_CYCLES synchronised cycles never reach btn_level.

Test Plan:
- STABLE_CYCLES=4. Reset, then btn_in 0->1 before edge 0 and held:
  - btn_level=1 at edge 6.
  - rise_pulse high for edge 6 only.
  - press_count=1.
  - busy high from edge 2 through edge 5.
- Bounce: btn_in high for 3 cycles, low for 2, high for 2, then low; repeat 5 times. btn_level, rise_pulse and press_count all stay 0, and busy toggles.
- Release: from HIGH, btn_in 1->0 held gives btn_level=0 and fall_pulse for one cycle at edge 6; press_count is unchanged.
- Wrap: PCNT_W=8, 256 clean press/release pairs. press_count reads 255 after pair 255 and 0 after pair 256.
- Reset mid-count: assert rst_n low while cnt=2 in CHK_HIGH. All outputs are 0 immediately, without waiting for a clock, and no rise_pulse appears afterward while btn_in=0.
- Held through reset: btn_in=1 during reset, release rst_n before edge 0. rise_pulse occurs at edge 6 and press_count=1.
